// File: rtl/sprite_pkg.sv
// Shared sprite geometry, motion limits and state encoding, used by the
// motion block and the sprite controller.
package sprite_pkg;

  localparam int SPR_X0           = 450;
  localparam int SPR_Y0           = 250;
  localparam int SPR_W            = 32;
  localparam int SPR_H            = 32;
  localparam int SPR_X_MIN        = 144;
  localparam int SPR_X_MAX        = 784;
  localparam int SPR_Y_MIN        = 35;
  localparam int SPR_Y_MAX        = 515;
  localparam int SPR_MAX_SPEED    = 4;
  localparam int SPR_ACCEL_FRAMES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    CRUISE = 2'd2
  } motion_state_t;

  // One axis step in 11-bit space, clamped to [lo, hi] so it never wraps.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        inc,
                                           input logic        dec,
                                           input logic [2:0]  spd,
                                           input logic [10:0] lo,
                                           input logic [10:0] hi);
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] r;
    p = {1'b0, pos};
    s = {8'd0, spd};
    r = p;
    if (inc && !dec) begin
      r = p + s;
      if (r > hi) r = hi;
    end else if (dec && !inc) begin
      if (p < lo + s) r = lo;
      else            r = p - s;
    end
    return r[9:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Produces a single-clock pulse when the raster enters pixel (0,0),
// no matter how many clocks the counters sit there.
module frame_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       frame_tick
);

  logic c;
  logic c_d;

  assign c = (hCount == 10'd0) && (vCount == 10'd0);

  always_ff @(posedge clk) begin
    if (rst) c_d <= 1'b0;
    else     c_d <= c;
  end

  // Reset masks the pulse so nothing downstream sees a tick while held.
  assign frame_tick = c & ~c_d & ~rst;

endmodule

// File: rtl/sprite_motion.sv
// Button-driven sprite position with per-frame updates, speed ramp-up and
// clamping to the visible window.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int X0           = SPR_X0,
  parameter int Y0           = SPR_Y0,
  parameter int W            = SPR_W,
  parameter int H            = SPR_H,
  parameter int X_MIN        = SPR_X_MIN,
  parameter int X_MAX        = SPR_X_MAX,
  parameter int Y_MIN        = SPR_Y_MIN,
  parameter int Y_MAX        = SPR_Y_MAX,
  parameter int MAX_SPEED    = SPR_MAX_SPEED,
  parameter int ACCEL_FRAMES = SPR_ACCEL_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       moving,
  output logic       frame_tick
);

  localparam logic [10:0] X_LO      = 11'(X_MIN);
  localparam logic [10:0] X_HI      = 11'(X_MAX - W);
  localparam logic [10:0] Y_LO      = 11'(Y_MIN);
  localparam logic [10:0] Y_HI      = 11'(Y_MAX - H);
  localparam logic [2:0]  SPEED_TOP = 3'(MAX_SPEED);
  localparam logic [2:0]  CNT_LAST  = 3'(ACCEL_FRAMES - 1);

  motion_state_t state, state_next;
  logic [2:0]    speed, speed_next;
  logic [2:0]    move_cnt, move_cnt_next;
  logic [9:0]    xpos_next, ypos_next;
  logic          x_inc, x_dec, y_inc, y_dec, active;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .hCount     (hCount),
    .vCount     (vCount),
    .frame_tick (frame_tick)
  );

  // Opposite buttons on one axis cancel out.
  assign x_inc  = btn_right & ~btn_left;
  assign x_dec  = btn_left  & ~btn_right;
  assign y_inc  = btn_down  & ~btn_up;
  assign y_dec  = btn_up    & ~btn_down;
  assign active = x_inc | x_dec | y_inc | y_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      speed    <= 3'd1;
      move_cnt <= 3'd0;
      xpos     <= 10'(X0);
      ypos     <= 10'(Y0);
    end else begin
      state    <= state_next;
      speed    <= speed_next;
      move_cnt <= move_cnt_next;
      xpos     <= xpos_next;
      ypos     <= ypos_next;
    end
  end

  always_comb begin
    state_next    = state;
    speed_next    = speed;
    move_cnt_next = move_cnt;
    xpos_next     = xpos;
    ypos_next     = ypos;
    if (frame_tick) begin
      if (!en || !active) begin
        state_next    = IDLE;
        speed_next    = 3'd1;
        move_cnt_next = 3'd0;
      end else begin
        xpos_next = step_axis(xpos, x_inc, x_dec, speed, X_LO, X_HI);
        ypos_next = step_axis(ypos, y_inc, y_dec, speed, Y_LO, Y_HI);
        // The move uses the current speed; any increment applies from the next frame.
        case (state)
          IDLE, RAMP: begin
            if (move_cnt == CNT_LAST) begin
              move_cnt_next = 3'd0;
              speed_next    = speed + 3'd1;
              state_next    = ((speed + 3'd1) >= SPEED_TOP) ? CRUISE : RAMP;
            end else begin
              move_cnt_next = move_cnt + 3'd1;
              state_next    = RAMP;
            end
          end
          CRUISE:  state_next = CRUISE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    moving = (state != IDLE);
  end

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: frames are emulated by parking the raster
// counters at (0,0) for a few clocks, so each runFrame call is one tick.
module tb_sprite_motion;
  import sprite_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] hCount, vCount;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] xpos, ypos;
  logic       moving, frame_tick;

  int testsRun  = 0;
  int failCount = 0;
  int tickCount = 0;
  int tickMark;

  sprite_motion dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .hCount     (hCount),
    .vCount     (vCount),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .xpos       (xpos),
    .ypos       (ypos),
    .moving     (moving),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_tick) tickCount <= tickCount + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic up, input logic down, input logic left,
                               input logic right, input logic enable);
    btn_up    = up;
    btn_down  = down;
    btn_left  = left;
    btn_right = right;
    en        = enable;
  endtask

  // Counters held at zero for three clocks, then moved on.
  task automatic runFrame(input int n);
    for (int i = 0; i < n; i++) begin
      hCount = 10'd0;
      vCount = 10'd0;
      repeat (3) step;
      hCount = 10'd1;
      step;
    end
  endtask

  initial begin
    rst    = 1'b1;
    hCount = 10'd0;
    vCount = 10'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step;
    checkOutput("tick_in_reset", 32'(frame_tick), 32'd0);
    hCount = 10'd1;
    step;
    rst = 1'b0;
    step;
    checkOutput("reset_x", 32'(xpos), 32'd450);
    checkOutput("reset_y", 32'(ypos), 32'd250);
    checkOutput("reset_moving", 32'(moving), 32'd0);

    tickMark = tickCount;
    runFrame(1);
    checkOutput("one_tick_per_frame", 32'(tickCount - tickMark), 32'd1);
    checkOutput("idle_x_held", 32'(xpos), 32'd450);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    runFrame(1);
    checkOutput("right1_x", 32'(xpos), 32'd451);
    checkOutput("right1_moving", 32'(moving), 32'd1);
    checkOutput("right1_state", 32'(dut.state), 32'(RAMP));
    runFrame(23);
    checkOutput("right24_x", 32'(xpos), 32'd498);
    checkOutput("right24_speed", 32'(dut.speed), 32'd4);
    checkOutput("right24_state", 32'(dut.state), 32'(CRUISE));
    runFrame(1);
    checkOutput("right25_x", 32'(xpos), 32'd502);
    checkOutput("right25_ticks", 32'(tickCount - tickMark), 32'd26);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    runFrame(89);
    checkOutput("left_x146", 32'(xpos), 32'd146);
    runFrame(1);
    checkOutput("left_clamp_x", 32'(xpos), 32'd144);
    checkOutput("left_clamp_state", 32'(dut.state), 32'(CRUISE));
    runFrame(1);
    checkOutput("left_clamp_hold", 32'(xpos), 32'd144);
    checkOutput("left_clamp_speed", 32'(dut.speed), 32'd4);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    runFrame(1);
    checkOutput("release_state", 32'(dut.state), 32'(IDLE));
    checkOutput("release_speed", 32'(dut.speed), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    runFrame(1);
    checkOutput("updown_y", 32'(ypos), 32'd250);
    checkOutput("updown_state", 32'(dut.state), 32'(IDLE));
    checkOutput("updown_moving", 32'(moving), 32'd0);

    rst = 1'b1;
    step;
    rst = 1'b0;
    checkOutput("repulse_x", 32'(xpos), 32'd450);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    runFrame(14);
    checkOutput("ramp_x470", 32'(xpos), 32'd470);
    checkOutput("ramp_speed2", 32'(dut.speed), 32'd2);
    rst    = 1'b1;
    hCount = 10'd0;
    vCount = 10'd0;
    step;
    checkOutput("midramp_rst_tick", 32'(frame_tick), 32'd0);
    checkOutput("midramp_rst_x", 32'(xpos), 32'd450);
    checkOutput("midramp_rst_speed", 32'(dut.speed), 32'd1);
    checkOutput("midramp_rst_moving", 32'(moving), 32'd0);
    hCount = 10'd1;
    rst    = 1'b0;
    step;

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tickMark = tickCount;
    runFrame(5);
    checkOutput("en0_x", 32'(xpos), 32'd450);
    checkOutput("en0_y", 32'(ypos), 32'd250);
    checkOutput("en0_moving", 32'(moving), 32'd0);
    checkOutput("en0_ticks", 32'(tickCount - tickMark), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    runFrame(1);
    checkOutput("diag_x", 32'(xpos), 32'd451);
    checkOutput("diag_y", 32'(ypos), 32'd251);
    checkOutput("diag_state", 32'(dut.state), 32'(RAMP));

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
